// File: rtl/mezz_pwm_bank.sv
// rtl/mezz_pwm_bank.sv - NUM_CH-channel PWM bank with double-buffered period/duty loaded at terminal count.
// Optional duty soft-start ramp when PWM_SOFTSTART_EN is defined.
module mezz_pwm_bank #(
    parameter int                NUM_CH         = 3,
    parameter int                CNT_W          = 16,
    parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = CNT_W'(999),
    parameter int                SS_STEP        = 1,
    localparam int               CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_wr_en,
    input  logic [CH_W-1:0]   cfg_wr_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] period_tick,
    output logic [NUM_CH-1:0] pwm_o
);

    // A ramp step of zero would freeze the duty forever.
    if (SS_STEP < 1) begin : g_ss_step_must_be_positive
    end

    logic [CNT_W-1:0]  cnt_q        [NUM_CH];
    logic [CNT_W-1:0]  cnt_d        [NUM_CH];
    logic [CNT_W-1:0]  period_act_q [NUM_CH];
    logic [CNT_W-1:0]  period_act_d [NUM_CH];
    logic [CNT_W-1:0]  duty_act_q   [NUM_CH];
    logic [CNT_W-1:0]  duty_act_d   [NUM_CH];
    logic [CNT_W-1:0]  pend_period_q[NUM_CH];
    logic [CNT_W-1:0]  pend_period_d[NUM_CH];
    logic [CNT_W-1:0]  pend_duty_q  [NUM_CH];
    logic [CNT_W-1:0]  pend_duty_d  [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              cfg_err_q, cfg_err_d;
    logic              wr_valid;

`ifdef PWM_SOFTSTART_EN
    localparam logic [CNT_W-1:0] SS_C = CNT_W'(SS_STEP);

    logic [CNT_W-1:0] target_q[NUM_CH];
    logic [CNT_W-1:0] target_d[NUM_CH];

    function automatic logic [CNT_W-1:0] ss_next(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt);
        if (cur < tgt)
            return ((tgt - cur) > SS_C) ? cur + SS_C : tgt;
        else
            return ((cur - tgt) > SS_C) ? cur - SS_C : tgt;
    endfunction
`endif

    always_comb begin
        wr_valid  = cfg_wr_en && ({1'b0, cfg_wr_ch} < (CH_W+1)'(NUM_CH));
        cfg_err_d = cfg_wr_en && !wr_valid;
        pend_d    = pend_q;
        tick_d    = '0;
        pwm_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic tc;
            logic load;
            cnt_d[i]         = cnt_q[i];
            period_act_d[i]  = period_act_q[i];
            duty_act_d[i]    = duty_act_q[i];
            pend_period_d[i] = pend_period_q[i];
            pend_duty_d[i]   = pend_duty_q[i];
            tc   = (cnt_q[i] == period_act_q[i]);
            // A disabled channel has no boundary to wait for.
            load = pend_q[i] && (!ch_en[i] || tc);

            if (load) begin
                period_act_d[i] = pend_period_q[i];
                pend_d[i]       = 1'b0;
            end
`ifdef PWM_SOFTSTART_EN
            target_d[i] = load ? pend_duty_q[i] : target_q[i];
            if (!ch_en[i])
                duty_act_d[i] = target_d[i];
            else if (tc)
                duty_act_d[i] = ss_next(duty_act_q[i], target_d[i]);
`else
            if (load)
                duty_act_d[i] = pend_duty_q[i];
`endif

            if (ch_en[i]) begin
                cnt_d[i]  = tc ? '0 : cnt_q[i] + 1'b1;
                tick_d[i] = tc;
                pwm_d[i]  = (cnt_q[i] < duty_act_q[i]);
            end else begin
                cnt_d[i] = '0;
            end

            // A write in the TC cycle lands after the load, so it waits for the next TC.
            if (wr_valid && (cfg_wr_ch == CH_W'(i))) begin
                pend_period_d[i] = cfg_period;
                pend_duty_d[i]   = cfg_duty;
                pend_d[i]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]         <= '0;
                period_act_q[i]  <= DEFAULT_PERIOD;
                duty_act_q[i]    <= '0;
                pend_period_q[i] <= '0;
                pend_duty_q[i]   <= '0;
`ifdef PWM_SOFTSTART_EN
                target_q[i]      <= '0;
`endif
            end
            pend_q    <= '0;
            tick_q    <= '0;
            pwm_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]         <= cnt_d[i];
                period_act_q[i]  <= period_act_d[i];
                duty_act_q[i]    <= duty_act_d[i];
                pend_period_q[i] <= pend_period_d[i];
                pend_duty_q[i]   <= pend_duty_d[i];
`ifdef PWM_SOFTSTART_EN
                target_q[i]      <= target_d[i];
`endif
            end
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            pwm_q     <= pwm_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err     = cfg_err_q;
    assign pend        = pend_q;
    assign period_tick = tick_q;
    assign pwm_o       = pwm_q;

endmodule
